// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multicycle RV32I core.
// Sequences fetch, decode, address generation, memory access, execute and
// write-back over the shared ALU and unified memory. Also counts retired
// instructions and latches a sticky flag on unsupported opcodes.
//
// Memory handshake: the controller presents a request (AdrSrc/MemWrite, or
// IRWrite in FETCH) every cycle it sits in FETCH, MEMREAD or MEMWRITE. An
// access completes on the rising edge where mem_ready is 1. The request is
// held unchanged until that edge. mem_ready is ignored in every other state.
module multicycle_controller #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [1:0]           ImmSrc,
  output logic                 RegWrite,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret,
  output logic [3:0]           state
);

  // Opcodes the core supports.
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Mux select encodings.
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Encodings are visible on the debug port, so they are pinned explicitly.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  state_t state_q;
  state_t state_n;
  logic   branch;
  logic   pcupdate;
  logic   retire;
  logic   illegal_q;

  // State register; reset may land in any state, including mid-access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state and per-state control outputs.
  always_comb begin
    state_n   = S_FETCH;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ALUOp     = ALUOP_ADD;
    RegWrite  = 1'b0;
    branch    = 1'b0;
    pcupdate  = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Address = PC; ALU computes PC+4 in parallel. The IR and PC only
        // load once the memory has actually returned the instruction.
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALURES;
        IRWrite   = mem_ready;
        pcupdate  = mem_ready;
        state_n   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // OldPC + imm: branch/jump target, harmless for other opcodes.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
        case (op)
          OP_LOAD, OP_STORE: state_n = S_MEMADR;
          OP_RTYPE:          state_n = S_EXECUTER;
          OP_ITYPE:          state_n = S_EXECUTEI;
          OP_BEQ:            state_n = S_BEQ;
          OP_JAL:            state_n = S_JAL;
          default:           state_n = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
        state_n = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        state_n   = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_n   = S_FETCH;
      end
      S_MEMWRITE: begin
        // Write strobe is held until the memory accepts it.
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        MemWrite  = 1'b1;
        retire    = mem_ready;
        state_n   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        ALUOp   = ALUOP_FUNC;
        state_n = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNC;
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_n   = S_FETCH;
      end
      S_BEQ: begin
        // rs1 - rs2; PC takes the target latched in DECODE when equal.
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_RD2;
        ALUOp     = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        branch    = 1'b1;
        retire    = 1'b1;
        state_n   = S_FETCH;
      end
      S_JAL: begin
        // PC <- target (ALUOut from DECODE); ALU forms the link OldPC+4.
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALUOUT;
        pcupdate  = 1'b1;
        state_n   = S_ALUWB;
      end
      S_ILLEGAL: begin
        // Parked with every strobe low until reset.
        state_n = S_ILLEGAL;
      end
      default: begin
        // Unused encodings recover to FETCH with all outputs low.
        state_n = S_FETCH;
      end
    endcase
  end

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_LOAD, OP_ITYPE: ImmSrc = IMM_I;
      OP_STORE:          ImmSrc = IMM_S;
      OP_BEQ:            ImmSrc = IMM_B;
      OP_JAL:            ImmSrc = IMM_J;
      default:           ImmSrc = IMM_I;
    endcase
  end

  assign PCWrite = (branch & zero) | pcupdate;

  // Retired-instruction counter, wraps naturally at 2^INSTRET_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + INSTRET_W'(1);
    end
  end

  // Sticky illegal flag, set on the same edge the FSM parks in ILLEGAL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (state_n == S_ILLEGAL) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core; sequences the shared ALU, instruction register, PC and unified memory over 3–5 cycles per instruction.
- Drives ALUOp into the existing ALU decoder, which turns ALUOp/funct3/funct7 into ALUControl.
- Handles memory wait states through a mem_ready handshake.
- Counts retired instructions and flags unsupported opcodes.

Parameters:
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- op  input  7  opcode field from the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current access this cycle.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction/OldPC register enable.
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  output  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- ALUOp  output  2  to ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded.
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- RegWrite  output  1  register file write enable.
- illegal  output  1  sticky unsupported-opcode flag.
- instret  output  INSTRET_W  retired-instruction count.
- state  output  4  current state encoding, for debug.

Behaviour:
- Reset (asynchronous, any state, including mid-access): state = FETCH (0), instret = 0, illegal = 0.
- All outputs are combinational from state, op, zero and mem_ready. Any output not listed for a state is 0.
- ImmSrc is decoded from op in every state:
  - 0000011 / 0010011 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - otherwise 00
- PCWrite = (Branch & zero) | PCUpdate. Branch and PCUpdate are internal signals.
- States, encodings, asserted outputs and next state:
  - FETCH 0: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10.
    - IRWrite and PCUpdate are asserted only when mem_ready = 1.
    - mem_ready = 0 → stay in FETCH; mem_ready = 1 → DECODE.
  - DECODE 1: ALUSrcA 01, ALUSrcB 01, ALUOp 00 (computes branch/jump target).
    - op 0000011 or 0100011 → MEMADR
    - op 0110011 → EXECUTER
    - op 0010011 → EXECUTEI
    - op 1100011 → BEQ
    - op 1101111 → JAL
    - any other op → ILLEGAL
  - MEMADR 2: ALUSrcA 10, ALUSrcB 01, ALUOp 00.
    - op 0000011 → MEMREAD; otherwise → MEMWRITE.
  - MEMREAD 3: AdrSrc 1, ResultSrc 00. Hold until mem_ready = 1, then → MEMWB.
  - MEMWB 4: ResultSrc 01, RegWrite 1 → FETCH.
  - MEMWRITE 5: AdrSrc 1, ResultSrc 00, MemWrite 1.
    - MemWrite stays high every cycle until mem_ready = 1, then → FETCH.
  - EXECUTER 6: ALUSrcA 10, ALUSrcB 00, ALUOp 10 → ALUWB.
  - EXECUTEI 7: ALUSrcA 10, ALUSrcB 01, ALUOp 10 → ALUWB.
  - ALUWB 8: ResultSrc 00, RegWrite 1 → FETCH.
  - BEQ 9: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1 → FETCH.
  - JAL 10: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1 → ALUWB.
  - ILLEGAL 11: illegal = 1. All strobes 0. Stays in ILLEGAL until reset.
  - Encodings 12–15: next state FETCH, all outputs 0.
- Latency with mem_ready tied to 1:
  - lw 5 cycles; sw 4; R-type 4; I-type 4; beq 3; jal 4.
  - Each mem_ready = 0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- instret increments by 1 on each exit to FETCH from MEMWB, MEMWRITE (with mem_ready), ALUWB or BEQ.
  - Wraps modulo 2^INSTRET_W.
  - Never increments on the path into ILLEGAL.
- If mem_ready is high outside FETCH/MEMREAD/MEMWRITE, it is ignored.

Test Plan:
- Reset, then R-type (op 0110011) with mem_ready = 1 → states 0,1,6,8,0. ALUOp = 10 in state 6. RegWrite = 1 only in state 8. instret 0 → 1.
- lw (0000011) with mem_ready low for 2 cycles in FETCH and 1 cycle in MEMREAD → 8 cycles total. IRWrite = 1 exactly once. RegWrite = 1 with ResultSrc = 01 in MEMWB.
- beq with zero = 1, then beq with zero = 0 → PCWrite = 1 in BEQ only for the first. ALUOp = 01 both times. instret +2.
- sw (0100011) with 3 mem_ready-low cycles in MEMWRITE → MemWrite high 4 consecutive cycles, AdrSrc = 1, then FETCH.
- op 1110011 → ILLEGAL (11): illegal = 1, state holds for 20 cycles, instret unchanged. Asserting reset returns state 0, illegal 0.
- INSTRET_W = 4: run 16 ALU instructions → instret wraps 15 → 0. Assert reset during MEMREAD → state 0 immediately (asynchronous), no RegWrite pulse.
